// File: rtl/pc_irq_source_if.sv
// CPU-side signals seen by pc_irq_source: committed PC and interrupt-space
// store in, interrupt request out. The master modport is the CPU/top-level
// side; the slave modport is the interrupt source.
interface pc_irq_source_if;
    logic [31:0] macroscopic_pc;
    logic [31:0] m_int_addr;
    logic [3:0]  m_int_byteen;
    logic        interrupt;

    modport master (
        output macroscopic_pc,
        output m_int_addr,
        output m_int_byteen,
        input  interrupt
    );

    modport slave (
        input  macroscopic_pc,
        input  m_int_addr,
        input  m_int_byteen,
        output interrupt
    );
endinterface

// File: rtl/pc_irq_source.sv
// pc_irq_source: raises an interrupt when the committed PC hits TARGET_PC and
// holds it until the handler stores to ACK_ADDR. An optional holdoff delays
// re-arming, and FIRE_LIMIT caps the total number of interrupts (0 = unlimited).
// Optional feature macro: PC_IRQ_TIMEOUT_EN adds an acknowledge deadline of
// TIMEOUT cycles with a sticky timeout_err flag.
module pc_irq_source #(
    parameter logic [31:0] ACK_ADDR   = 32'h0000_7f20,
    parameter logic [31:0] TARGET_PC  = 32'h0000_3010,
    parameter logic [7:0]  FIRE_LIMIT = 8'd1,
    parameter logic [15:0] HOLDOFF    = 16'd0,
    parameter logic [15:0] TIMEOUT    = 16'd1024
) (
    input  logic             clk,
    input  logic             reset,
    pc_irq_source_if.slave   cpu,
    output logic [7:0]       fire_count,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_ASSERT,
        ST_HOLDOFF,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  fire_cnt_q, fire_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic        irq_q, irq_d;
    logic        busy_q, busy_d;
    logic        pc_was_match_q;

    logic match, ack, fire, tmo_hit, release_irq, limit_hit;

    assign match = (cpu.macroscopic_pc & 32'hffff_fffc) == (TARGET_PC & 32'hffff_fffc);
    assign ack   = (|cpu.m_int_byteen) &&
                   ((cpu.m_int_addr & 32'hffff_fffc) == (ACK_ADDR & 32'hffff_fffc));

    // A PC parked on the target fires only on its first matching cycle.
    assign fire        = (state_q == ST_ARMED) && match && !pc_was_match_q;
    assign release_irq = (state_q == ST_ASSERT) && (ack || tmo_hit);
    assign limit_hit   = (FIRE_LIMIT != 8'd0) && (fire_cnt_q >= FIRE_LIMIT);

`ifdef PC_IRQ_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_err_q, tmo_err_d;

    // Deadline reached on the edge that would bring the count to TIMEOUT.
    assign tmo_hit = (state_q == ST_ASSERT) &&
                     (({1'b0, tmo_cnt_q} + 17'd1) == {1'b0, TIMEOUT});

    // Deadline counter runs only in ASSERT and restarts at zero on each entry.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_err_d = tmo_err_q;
        if (state_q == ST_ASSERT && state_d == ST_ASSERT)
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        if (tmo_hit && !ack)
            tmo_err_d = 1'b1;
    end

    // Deadline counter and sticky error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // State, counters, registered outputs and PC edge flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_ARMED;
            fire_cnt_q     <= '0;
            hold_cnt_q     <= '0;
            irq_q          <= 1'b0;
            busy_q         <= 1'b0;
            pc_was_match_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fire_cnt_q     <= fire_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            irq_q          <= irq_d;
            busy_q         <= busy_d;
            pc_was_match_q <= match;
        end
    end

    // Next-state: ARMED -> ASSERT -> (HOLDOFF) -> ARMED or DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARMED:   if (fire) state_d = ST_ASSERT;
            ST_ASSERT:  if (release_irq) begin
                            if (HOLDOFF != 16'd0) state_d = ST_HOLDOFF;
                            else                  state_d = limit_hit ? ST_DONE : ST_ARMED;
                        end
            ST_HOLDOFF: if (hold_cnt_q == 16'd0)
                            state_d = limit_hit ? ST_DONE : ST_ARMED;
            ST_DONE:    state_d = ST_DONE;
            default:    state_d = ST_ARMED;
        endcase
    end

    // Next values of the registered outputs and the fire/holdoff counters.
    always_comb begin
        irq_d      = (state_d == ST_ASSERT);
        busy_d     = (state_d == ST_ASSERT) || (state_d == ST_HOLDOFF);
        fire_cnt_d = fire_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (fire && fire_cnt_q != 8'hff)
            fire_cnt_d = fire_cnt_q + 8'd1;
        if (state_q == ST_ASSERT && state_d == ST_HOLDOFF)
            hold_cnt_d = HOLDOFF - 16'd1;
        else if (state_q == ST_HOLDOFF && hold_cnt_q != 16'd0)
            hold_cnt_d = hold_cnt_q - 16'd1;
    end

    assign cpu.interrupt = irq_q;
    assign fire_count    = fire_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_pc_irq_source.sv
// Directed bench for pc_irq_source: a default-parameter instance and an
// unlimited/holdoff instance (FIRE_LIMIT=0, HOLDOFF=3, TIMEOUT=16).
module tb_pc_irq_source;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] fc1, fc2;
    logic busy1, busy2, terr1, terr2;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    pc_irq_source_if bus1 ();
    pc_irq_source_if bus2 ();

    always #5 clk = ~clk;

    pc_irq_source u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .cpu         (bus1.slave),
        .fire_count  (fc1),
        .busy        (busy1),
        .timeout_err (terr1)
    );

    pc_irq_source #(
        .FIRE_LIMIT (8'd0),
        .HOLDOFF    (16'd3),
        .TIMEOUT    (16'd16)
    ) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .cpu         (bus2.slave),
        .fire_count  (fc2),
        .busy        (busy2),
        .timeout_err (terr2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store1(input logic [31:0] addr, input logic [3:0] be);
        bus1.m_int_addr   = addr;
        bus1.m_int_byteen = be;
    endtask

    task automatic store2(input logic [31:0] addr, input logic [3:0] be);
        bus2.m_int_addr   = addr;
        bus2.m_int_byteen = be;
    endtask

    initial begin
        bus1.macroscopic_pc = 32'h0;
        bus2.macroscopic_pc = 32'h0;
        store1(32'h0, 4'h0);
        store2(32'h0, 4'h0);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        check("rst_irq", {31'b0, bus1.interrupt}, 32'd0);
        check("rst_fc", {24'b0, fc1}, 32'd0);
        check("rst_busy", {31'b0, busy1}, 32'd0);
        check("rst_terr", {31'b0, terr1}, 32'd0);

        // Default instance: PC walk up to the target.
        for (int unsigned k = 0; k < 4; k++) begin
            bus1.macroscopic_pc = 32'h3000 + 32'(k * 4);
            step();
        end
        check("pre_match_irq", {31'b0, bus1.interrupt}, 32'd0);
        bus1.macroscopic_pc = 32'h3010;
        step();
        check("match_irq", {31'b0, bus1.interrupt}, 32'd1);
        check("match_fc", {24'b0, fc1}, 32'd1);
        check("match_busy", {31'b0, busy1}, 32'd1);
        bus1.macroscopic_pc = 32'h3014;
        store1(32'h7f24, 4'hf);
        step();
        check("wrong_addr_ack", {31'b0, bus1.interrupt}, 32'd1);
        store1(32'h7f20, 4'h0);
        step();
        check("zero_be_ack", {31'b0, bus1.interrupt}, 32'd1);
        store1(32'h7f20, 4'hf);
        step();
        check("ack_irq", {31'b0, bus1.interrupt}, 32'd0);
        check("ack_busy", {31'b0, busy1}, 32'd0);
        store1(32'h0, 4'h0);
        bus1.macroscopic_pc = 32'h3000;
        step();
        bus1.macroscopic_pc = 32'h3010;
        step(2);
        check("done_no_refire", {31'b0, bus1.interrupt}, 32'd0);
        check("done_fc", {24'b0, fc1}, 32'd1);

        // Low PC bits ignored; reset during ASSERT; match+ack same cycle.
        bus1.macroscopic_pc = 32'h3000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus1.macroscopic_pc = 32'h3012;
        step();
        check("lowbits_irq", {31'b0, bus1.interrupt}, 32'd1);
        reset = 1'b1;
        step();
        check("rst_assert_irq", {31'b0, bus1.interrupt}, 32'd0);
        check("rst_assert_fc", {24'b0, fc1}, 32'd0);
        check("rst_assert_busy", {31'b0, busy1}, 32'd0);
        reset = 1'b0;
        bus1.macroscopic_pc = 32'h3000;
        step();
        bus1.macroscopic_pc = 32'h3010;
        store1(32'h7f20, 4'h1);
        step();
        check("match_ack_irq", {31'b0, bus1.interrupt}, 32'd1);
        check("match_ack_fc", {24'b0, fc1}, 32'd1);
        store1(32'h0, 4'h0);
        step();
        check("match_ack_hold", {31'b0, bus1.interrupt}, 32'd1);

        // Second instance: unlimited fires with a 3-cycle holdoff.
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus2.macroscopic_pc = 32'h3000;
        step();
        bus2.macroscopic_pc = 32'h3010;
        step();
        check("h_fire1_irq", {31'b0, bus2.interrupt}, 32'd1);
        check("h_fire1_fc", {24'b0, fc2}, 32'd1);
        bus2.macroscopic_pc = 32'h3014;
        step();
        store2(32'h7f20, 4'hf);
        step();
        check("h_ack_irq", {31'b0, bus2.interrupt}, 32'd0);
        check("h_ack_busy0", {31'b0, busy2}, 32'd1);
        store2(32'h0, 4'h0);
        step();
        check("h_busy1", {31'b0, busy2}, 32'd1);
        step();
        check("h_busy2", {31'b0, busy2}, 32'd1);
        step();
        check("h_rearmed", {31'b0, busy2}, 32'd0);
        bus2.macroscopic_pc = 32'h3010;
        step();
        check("h_fire2_irq", {31'b0, bus2.interrupt}, 32'd1);
        check("h_fire2_fc", {24'b0, fc2}, 32'd2);

        // PC held on the target across re-arm: no fire until it leaves.
        store2(32'h7f20, 4'hf);
        step();
        store2(32'h0, 4'h0);
        step(3);
        check("held_rearm_busy", {31'b0, busy2}, 32'd0);
        step(2);
        check("held_no_fire", {31'b0, bus2.interrupt}, 32'd0);
        check("held_fc", {24'b0, fc2}, 32'd2);
        bus2.macroscopic_pc = 32'h3000;
        step();
        bus2.macroscopic_pc = 32'h3010;
        step();
        check("h_fire3_irq", {31'b0, bus2.interrupt}, 32'd1);
        check("h_fire3_fc", {24'b0, fc2}, 32'd3);

        // Acknowledge deadline (interrupt rose on the previous edge).
`ifdef PC_IRQ_TIMEOUT_EN
        step(15);
        check("tmo_before", {31'b0, bus2.interrupt}, 32'd1);
        check("tmo_err_before", {31'b0, terr2}, 32'd0);
        step();
        check("tmo_drop", {31'b0, bus2.interrupt}, 32'd0);
        check("tmo_err", {31'b0, terr2}, 32'd1);
        step(5);
        check("tmo_err_sticky", {31'b0, terr2}, 32'd1);
        check("tmo_no_refire", {31'b0, bus2.interrupt}, 32'd0);
`else
        step(1000);
        check("no_tmo_irq", {31'b0, bus2.interrupt}, 32'd1);
        check("no_tmo_err", {31'b0, terr2}, 32'd0);
        check("no_tmo_busy", {31'b0, busy2}, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
